// File: rtl/hub_slot_arb_if.sv
// Hub slot bus between the arbiter (master) and the cog array / hub (slave).
// The arbiter samples requests and drives the phase enable and slot grant.
interface hub_slot_arb_if #(
    parameter int IDLE_CNT_W = 16
);
    logic                  mode;
    logic [7:0]            cog_ena;
    logic [7:0]            bus_req;
    logic                  ena_bus;
    logic [7:0]            bus_sel;
    logic [2:0]            slot_cog;
    logic                  slot_valid;
    logic                  wrap;
    logic                  mode_act;
    logic [IDLE_CNT_W-1:0] idle_cnt;

    modport master (
        input  mode, cog_ena, bus_req,
        output ena_bus, bus_sel, slot_cog, slot_valid, wrap, mode_act, idle_cnt
    );

    modport slave (
        output mode, cog_ena, bus_req,
        input  ena_bus, bus_sel, slot_cog, slot_valid, wrap, mode_act, idle_cnt
    );
endinterface

// File: rtl/hub_slot_arb.sv
// Hub slot arbiter: two-clock ena_bus phase plus one-hot bus_sel grant,
// either fixed P1 rotation (mode 0) or demand-driven round robin (mode 1).
module hub_slot_arb #(
    parameter int IDLE_CNT_W = 16
) (
    input  logic           clk_cog,
    input  logic           nres,
    hub_slot_arb_if.master hub
);
    logic                  ena_bus_reg;
    logic [7:0]            bus_sel_reg, bus_sel_next;
    logic [2:0]            ptr_reg, ptr_next;
    logic                  mode_act_reg, mode_act_next;
    logic                  wrap_reg, wrap_next;
    logic [IDLE_CNT_W-1:0] idle_cnt_reg, idle_cnt_next;

    logic [7:0] eligible;
    logic [7:0] eligible_rot;
    logic [2:0] search_base;
    logic [2:0] grant_off;
    logic [2:0] grant_idx;
    logic       grant_found;
    logic       mode_sync;
    logic [2:0] slot_cog;

    assign eligible = hub.bus_req & hub.cog_ena;

    // A mode-0 history means the demand search restarts just after cog 7.
    assign search_base = mode_act_reg ? ptr_reg : 3'd7;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign eligible_rot[gi] = eligible[search_base + 3'd1 + 3'(gi)];
        end
    endgenerate

    always_comb begin
        grant_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible_rot[i]) grant_off = 3'(i);
        end
    end

    assign grant_found = |eligible_rot;
    assign grant_idx   = search_base + 3'd1 + grant_off;

    // Mode changes only take effect at a slot boundary of the fixed rotation.
    assign mode_sync = (bus_sel_reg == 8'h00) || (bus_sel_reg == 8'h80);

    always_comb begin
        mode_act_next = mode_sync ? hub.mode : mode_act_reg;
        bus_sel_next  = 8'h00;
        ptr_next      = ptr_reg;
        wrap_next     = 1'b0;
        idle_cnt_next = idle_cnt_reg;
        if (!mode_act_next) begin
            bus_sel_next = {bus_sel_reg[6:0], ~|bus_sel_reg[6:0]};
            ptr_next     = 3'd7;
            wrap_next    = (bus_sel_next == 8'h01);
        end else if (grant_found) begin
            bus_sel_next = 8'h01 << grant_idx;
            ptr_next     = grant_idx;
        end else if (!(&idle_cnt_reg)) begin
            idle_cnt_next = idle_cnt_reg + IDLE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            ena_bus_reg  <= 1'b0;
            bus_sel_reg  <= 8'h00;
            ptr_reg      <= 3'd7;
            mode_act_reg <= 1'b0;
            wrap_reg     <= 1'b0;
            idle_cnt_reg <= '0;
        end else begin
            ena_bus_reg <= !ena_bus_reg;
            if (ena_bus_reg) begin
                bus_sel_reg  <= bus_sel_next;
                ptr_reg      <= ptr_next;
                mode_act_reg <= mode_act_next;
                wrap_reg     <= wrap_next;
                idle_cnt_reg <= idle_cnt_next;
            end else begin
                wrap_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        slot_cog = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus_sel_reg[i]) slot_cog = slot_cog | 3'(i);
        end
    end

    assign hub.ena_bus    = ena_bus_reg;
    assign hub.bus_sel    = bus_sel_reg;
    assign hub.slot_cog   = slot_cog;
    assign hub.slot_valid = |bus_sel_reg;
    assign hub.wrap       = wrap_reg;
    assign hub.mode_act   = mode_act_reg;
    assign hub.idle_cnt   = idle_cnt_reg;

    a_bus_sel_onehot0: assert property (@(posedge clk_cog) disable iff (!nres) $onehot0(bus_sel_reg));
endmodule

// File: tb/tb_hub_slot_arb.sv
// Directed bench for hub_slot_arb: fixed rotation, demand grants, idle
// saturation, deferred mode switch, masked cogs and asynchronous reset.
module tb_hub_slot_arb;
    logic clk_cog = 1'b0;
    logic nres    = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    hub_slot_arb_if #(.IDLE_CNT_W(4)) hub ();

    hub_slot_arb #(.IDLE_CNT_W(4)) dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .hub     (hub.master)
    );

    always #5 clk_cog = ~clk_cog;

    task automatic do_reset(input logic m, input logic [7:0] ena, input logic [7:0] req);
        nres        = 1'b0;
        hub.mode    = m;
        hub.cog_ena = ena;
        hub.bus_req = req;
        repeat (2) @(negedge clk_cog);
        nres = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 8'hFF, 8'h00);
        vectors++;
        if ({hub.ena_bus, hub.bus_sel, hub.wrap, hub.mode_act, hub.idle_cnt, hub.slot_valid} !== 16'h0) begin
            $display("FAIL reset_state: got ena=%b sel=%h wrap=%b mact=%b idle=%h valid=%b, want all 0",
                     hub.ena_bus, hub.bus_sel, hub.wrap, hub.mode_act, hub.idle_cnt, hub.slot_valid);
            miscompares++;
        end
        $display("reset: sel=%h ena=%b", hub.bus_sel, hub.ena_bus);
    endtask

    task automatic test_fixed_rotation();
        logic [7:0] exp_sel [20] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10,
                                     8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
        logic [2:0] exp_cog [20] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
                                     3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
        do_reset(1'b0, 8'h00, 8'hFF);
        for (int n = 0; n < 20; n++) begin
            logic exp_ena;
            logic exp_wrap;
            @(negedge clk_cog);
            exp_ena  = (n % 2 == 0);
            exp_wrap = (n == 1) || (n == 17);
            vectors++;
            if (hub.bus_sel !== exp_sel[n] || hub.slot_cog !== exp_cog[n] || hub.ena_bus !== exp_ena ||
                hub.wrap !== exp_wrap || hub.slot_valid !== (exp_sel[n] != 8'h00)) begin
                $display("FAIL rotation[%0d]: got sel=%h cog=%0d ena=%b wrap=%b valid=%b, want sel=%h cog=%0d ena=%b wrap=%b",
                         n + 1, hub.bus_sel, hub.slot_cog, hub.ena_bus, hub.wrap, hub.slot_valid,
                         exp_sel[n], exp_cog[n], exp_ena, exp_wrap);
                miscompares++;
            end
            $display("rotation clk %0d: sel=%h cog=%0d wrap=%b", n + 1, hub.bus_sel, hub.slot_cog, hub.wrap);
        end
    endtask

    task automatic test_demand();
        logic [7:0] exp_sel [10] = '{8'h00, 8'h04, 8'h04, 8'h20, 8'h20, 8'h04, 8'h04, 8'h20, 8'h20, 8'h04};
        do_reset(1'b1, 8'hFF, 8'h24);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_cog);
            vectors++;
            if (hub.bus_sel !== exp_sel[n] || hub.idle_cnt !== 4'h0 || (n > 0 && hub.mode_act !== 1'b1)) begin
                $display("FAIL demand[%0d]: got sel=%h idle=%h mact=%b, want sel=%h idle=0 mact=%b",
                         n + 1, hub.bus_sel, hub.idle_cnt, hub.mode_act, exp_sel[n], n > 0);
                miscompares++;
            end
            $display("demand clk %0d: sel=%h", n + 1, hub.bus_sel);
        end
    endtask

    task automatic test_idle_saturate();
        do_reset(1'b1, 8'hFF, 8'h00);
        for (int n = 1; n <= 36; n++) begin
            logic [3:0] exp_idle;
            @(negedge clk_cog);
            exp_idle = (n / 2 > 15) ? 4'hF : 4'(n / 2);
            vectors++;
            if (hub.idle_cnt !== exp_idle || hub.bus_sel !== 8'h00 || hub.slot_valid !== 1'b0) begin
                $display("FAIL idle[%0d]: got idle=%h sel=%h valid=%b, want idle=%h sel=00 valid=0",
                         n, hub.idle_cnt, hub.bus_sel, hub.slot_valid, exp_idle);
                miscompares++;
            end
            $display("idle clk %0d: idle_cnt=%h", n, hub.idle_cnt);
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] exp_sel [16] = '{8'h08, 8'h10, 8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80,
                                     8'h80, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
        do_reset(1'b0, 8'hFF, 8'h02);
        repeat (8) @(negedge clk_cog);
        vectors++;
        if (hub.bus_sel !== 8'h08) begin
            $display("FAIL switch_pre: got sel=%h, want 08", hub.bus_sel);
            miscompares++;
        end
        hub.mode = 1'b1;
        for (int n = 0; n < 16; n++) begin
            logic exp_mact;
            @(negedge clk_cog);
            exp_mact = (n >= 9);
            vectors++;
            if (hub.bus_sel !== exp_sel[n] || hub.mode_act !== exp_mact || hub.wrap !== 1'b0) begin
                $display("FAIL switch[%0d]: got sel=%h mact=%b wrap=%b, want sel=%h mact=%b wrap=0",
                         n + 9, hub.bus_sel, hub.mode_act, hub.wrap, exp_sel[n], exp_mact);
                miscompares++;
            end
            $display("switch clk %0d: sel=%h mact=%b", n + 9, hub.bus_sel, hub.mode_act);
        end
    endtask

    task automatic test_masked_cog();
        logic [7:0] exp_sel [6] = '{8'h01, 8'h80, 8'h80, 8'h01, 8'h01, 8'h80};
        do_reset(1'b1, 8'h01, 8'h81);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_cog);
            vectors++;
            if (hub.bus_sel !== ((n == 1) ? 8'h00 : 8'h01) || hub.wrap !== 1'b0) begin
                $display("FAIL masked[%0d]: got sel=%h wrap=%b, want sel=%h wrap=0",
                         n, hub.bus_sel, hub.wrap, (n == 1) ? 8'h00 : 8'h01);
                miscompares++;
            end
            $display("masked clk %0d: sel=%h", n, hub.bus_sel);
        end
        hub.cog_ena = 8'hFF;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_cog);
            vectors++;
            if (hub.bus_sel !== exp_sel[n]) begin
                $display("FAIL unmasked[%0d]: got sel=%h, want %h", n + 9, hub.bus_sel, exp_sel[n]);
                miscompares++;
            end
            $display("unmasked clk %0d: sel=%h", n + 9, hub.bus_sel);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_sel [3] = '{8'h00, 8'h00, 8'h01};
        do_reset(1'b0, 8'hFF, 8'h00);
        repeat (13) @(negedge clk_cog);
        vectors++;
        if (hub.bus_sel !== 8'h20 || hub.ena_bus !== 1'b1) begin
            $display("FAIL areset_pre: got sel=%h ena=%b, want sel=20 ena=1", hub.bus_sel, hub.ena_bus);
            miscompares++;
        end
        #2 nres = 1'b0;
        #1;
        vectors++;
        if ({hub.ena_bus, hub.bus_sel, hub.slot_cog, hub.slot_valid, hub.wrap, hub.mode_act, hub.idle_cnt} !== 19'h0) begin
            $display("FAIL areset: got ena=%b sel=%h cog=%0d valid=%b wrap=%b mact=%b idle=%h, want all 0",
                     hub.ena_bus, hub.bus_sel, hub.slot_cog, hub.slot_valid, hub.wrap, hub.mode_act, hub.idle_cnt);
            miscompares++;
        end
        $display("areset mid-slot: sel=%h ena=%b", hub.bus_sel, hub.ena_bus);
        @(negedge clk_cog);
        nres = 1'b1;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) @(negedge clk_cog);
            vectors++;
            if (hub.bus_sel !== exp_sel[n]) begin
                $display("FAIL areset_restart[%0d]: got sel=%h, want %h", n, hub.bus_sel, exp_sel[n]);
                miscompares++;
            end
            $display("restart clk %0d: sel=%h", n, hub.bus_sel);
        end
    endtask

    initial begin
        hub.mode    = 1'b0;
        hub.cog_ena = 8'h00;
        hub.bus_req = 8'h00;
        test_reset();
        test_fixed_rotation();
        test_demand();
        test_idle_saturate();
        test_mode_switch();
        test_masked_cog();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
